// File: rtl/time_adjust_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : time_adjust_ctrl
// Brief    : Hour/minute/second keeper shared between the 1 Hz tick and the
//            key-driven edit path, with blink strobe and day-carry pulse.
// Revision : 1.0  initial release
// ============================================================================
module time_adjust_ctrl #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] model,
    input  logic [1:0] adjust_shif,
    input  logic       key_up,
    input  logic       key_down,
    output logic [4:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic       day_carry,
    output logic       adj_active,
    output logic       blink
);

    localparam int                    c_PCNT_W   = $clog2(TICK_DIV);
    localparam logic [c_PCNT_W-1:0]   c_PCNT_MAX = c_PCNT_W'(TICK_DIV - 1);
    localparam int                    c_HALF     = TICK_DIV / 2;
    localparam int                    c_BCNT_W   = (c_HALF > 1) ? $clog2(c_HALF) : 1;
    localparam logic [c_BCNT_W-1:0]   c_BCNT_MAX = c_BCNT_W'(c_HALF - 1);

    localparam logic [0:0] c_S_RUN = 1'b0;
    localparam logic [0:0] c_S_ADJ = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_next_state;
    logic [c_PCNT_W-1:0] r_pcnt;
    logic [c_BCNT_W-1:0] r_bcnt;
    logic                r_blink;
    logic [4:0]          r_hour;
    logic [5:0]          r_minute;
    logic [5:0]          r_second;
    logic                r_day_carry;

    logic       w_run_stay;
    logic       w_adj_stay;
    logic       w_adj_enter;
    logic       w_tick;
    logic       w_edit_up;
    logic       w_edit_dn;
    logic [4:0] w_hour_nxt;
    logic [5:0] w_minute_nxt;
    logic [5:0] w_second_nxt;
    logic       w_day_wrap;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next_state = c_S_RUN;
        if (model == 2'b11) begin
            w_next_state = c_S_ADJ;
        end
    end

    // ---------------- state-derived outputs/qualifiers ----------------
    always_comb begin
        w_run_stay  = (r_state == c_S_RUN) && (w_next_state == c_S_RUN);
        w_adj_stay  = (r_state == c_S_ADJ) && (w_next_state == c_S_ADJ);
        w_adj_enter = (r_state == c_S_RUN) && (w_next_state == c_S_ADJ);
        adj_active  = (r_state == c_S_ADJ);
        blink       = r_blink;
    end

    // A tick landing on the ADJ entry edge is dropped, so qualify with w_run_stay.
    assign w_tick    = w_run_stay && (r_pcnt == c_PCNT_MAX);
    assign w_edit_up = w_adj_stay && key_up && !key_down && (adjust_shif != 2'b11);
    assign w_edit_dn = w_adj_stay && key_down && !key_up && (adjust_shif != 2'b11);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt <= '0;
        end else if (w_run_stay) begin
            r_pcnt <= (r_pcnt == c_PCNT_MAX) ? '0 : r_pcnt + c_PCNT_W'(1);
        end else begin
            r_pcnt <= '0;
        end
    end

    always_comb begin
        w_hour_nxt   = r_hour;
        w_minute_nxt = r_minute;
        w_second_nxt = r_second;
        w_day_wrap   = 1'b0;
        if (w_tick) begin
            if (r_second == 6'd59) begin
                w_second_nxt = 6'd0;
                if (r_minute == 6'd59) begin
                    w_minute_nxt = 6'd0;
                    if (r_hour == 5'd23) begin
                        w_hour_nxt = 5'd0;
                        w_day_wrap = 1'b1;
                    end else begin
                        w_hour_nxt = r_hour + 5'd1;
                    end
                end else begin
                    w_minute_nxt = r_minute + 6'd1;
                end
            end else begin
                w_second_nxt = r_second + 6'd1;
            end
        end else if (w_edit_up) begin
            case (adjust_shif)
                2'b00:   w_second_nxt = (r_second == 6'd59) ? 6'd0 : r_second + 6'd1;
                2'b01:   w_minute_nxt = (r_minute == 6'd59) ? 6'd0 : r_minute + 6'd1;
                2'b10:   w_hour_nxt   = (r_hour == 5'd23)   ? 5'd0 : r_hour + 5'd1;
                default: ;
            endcase
        end else if (w_edit_dn) begin
            case (adjust_shif)
                2'b00:   w_second_nxt = (r_second == 6'd0) ? 6'd59 : r_second - 6'd1;
                2'b01:   w_minute_nxt = (r_minute == 6'd0) ? 6'd59 : r_minute - 6'd1;
                2'b10:   w_hour_nxt   = (r_hour == 5'd0)   ? 5'd23 : r_hour - 5'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hour      <= '0;
            r_minute    <= '0;
            r_second    <= '0;
            r_day_carry <= 1'b0;
        end else begin
            r_hour      <= w_hour_nxt;
            r_minute    <= w_minute_nxt;
            r_second    <= w_second_nxt;
            r_day_carry <= w_day_wrap;
        end
    end

    // Blink starts high on ADJ entry and flips every half tick period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcnt  <= '0;
            r_blink <= 1'b0;
        end else if (w_adj_enter) begin
            r_bcnt  <= '0;
            r_blink <= 1'b1;
        end else if (w_adj_stay) begin
            if (r_bcnt == c_BCNT_MAX) begin
                r_bcnt  <= '0;
                r_blink <= ~r_blink;
            end else begin
                r_bcnt  <= r_bcnt + c_BCNT_W'(1);
            end
        end else begin
            r_bcnt  <= '0;
            r_blink <= 1'b0;
        end
    end

    assign hour      = r_hour;
    assign minute    = r_minute;
    assign second    = r_second;
    assign day_carry = r_day_carry;

endmodule
`default_nettype wire
